// File: rtl/brq_if.sv
// Branch resolve queue bus: predict-side push, execute-side resolve, predictor update.
// Optional statistics outputs are present when BRQ_STATS_EN is defined.
interface brq_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             enq_valid;
  logic [PC_W-1:0]  enq_pc;
  logic             enq_gpred;
  logic             enq_ppred;
  logic             enq_pred;
  logic             enq_ready;
  logic             res_valid;
  logic             res_taken;
  logic             flush;
  logic             update;
  logic [PC_W-1:0]  update_pc;
  logic             g_reality;
  logic             p_reality;
  logic             reality;
  logic             mispredict;
  logic [CNT_W-1:0] count;
  logic             underflow;
`ifdef BRQ_STATS_EN
  logic [15:0]      stat_resolved;
  logic [15:0]      stat_mispred;
`endif

  modport slave (
    input  enq_valid, enq_pc, enq_gpred, enq_ppred, enq_pred,
    input  res_valid, res_taken, flush,
    output enq_ready, update, update_pc, g_reality, p_reality, reality,
    output mispredict, count, underflow
`ifdef BRQ_STATS_EN
    , output stat_resolved, stat_mispred
`endif
  );

  modport master (
    output enq_valid, enq_pc, enq_gpred, enq_ppred, enq_pred,
    output res_valid, res_taken, flush,
    input  enq_ready, update, update_pc, g_reality, p_reality, reality,
    input  mispredict, count, underflow
`ifdef BRQ_STATS_EN
    , input stat_resolved, stat_mispred
`endif
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions feeding the tournament predictor update port.
// Define BRQ_STATS_EN to add saturating resolve/mispredict counters.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  brq_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            gpred;
    logic            ppred;
    logic            pred;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_nxt;
  logic [CNT_W-1:0] cnt;
  entry_t           head_e;
  logic             empty;
  logic             do_res;
  logic             mis;
  logic             discard;
  logic             do_push;

  assign empty         = (cnt == '0);
  assign head_e        = mem[head];
  assign do_res        = bus.res_valid & ~empty;
  assign mis           = do_res & (head_e.pred != bus.res_taken);
  // A mispredict squashes every younger entry, exactly like an external flush.
  assign discard       = bus.flush | mis;
  assign bus.enq_ready = (cnt != CNT_W'(DEPTH));
  assign do_push       = bus.enq_valid & bus.enq_ready & ~discard;
  assign head_nxt      = head + PTR_W'(do_res);
  assign bus.count     = cnt;

  // NOTE: entry storage has no reset; occupancy is tracked by cnt, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= {bus.enq_pc, bus.enq_gpred, bus.enq_ppred, bus.enq_pred};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (discard) begin
      head <= head_nxt;
      tail <= head_nxt;
      cnt  <= '0;
    end else begin
      head <= head_nxt;
      if (do_push) tail <= tail + PTR_W'(1);
      cnt  <= cnt + CNT_W'(do_push) - CNT_W'(do_res);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.update     <= 1'b0;
      bus.update_pc  <= '0;
      bus.g_reality  <= 1'b0;
      bus.p_reality  <= 1'b0;
      bus.reality    <= 1'b0;
      bus.mispredict <= 1'b0;
      bus.underflow  <= 1'b0;
    end else begin
      bus.update     <= do_res;
      bus.mispredict <= mis;
      bus.underflow  <= bus.underflow | (bus.res_valid & empty);
      if (do_res) begin
        bus.update_pc <= head_e.pc;
        bus.g_reality <= (head_e.gpred == bus.res_taken);
        bus.p_reality <= (head_e.ppred == bus.res_taken);
        bus.reality   <= bus.res_taken;
      end
    end
  end

`ifdef BRQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.stat_resolved <= '0;
      bus.stat_mispred  <= '0;
    end else begin
      if (do_res && bus.stat_resolved != 16'hFFFF) bus.stat_resolved <= bus.stat_resolved + 16'd1;
      if (mis && bus.stat_mispred != 16'hFFFF)     bus.stat_mispred  <= bus.stat_mispred + 16'd1;
    end
  end
`endif
endmodule
